// File: rtl/sdram_write_buffer.sv
// Write-path feeder for the SDRAM controller: pixel FIFO plus full-page burst requester.
// Optional macro SDRAM_WBUF_DROP_CNT_EN enables the saturating dropped-push counter.
module sdram_write_buffer #(
    parameter int unsigned DEPTH_LOG2   = 10,
    parameter int unsigned BURST_LEN    = 512,
    parameter int unsigned FRAME_BURSTS = 600,
    parameter logic [14:0] BASE_ADDR    = 15'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           pix_data,
    input  logic                  pix_valid,
    input  logic                  frame_start,
    input  logic                  ready,
    input  logic                  f2s_data_valid,
    output logic                  rw_en,
    output logic                  rw,
    output logic [14:0]           f_addr,
    output logic [15:0]           f2s_data,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic                  busy,
    output logic                  overflow,
    output logic [15:0]           drop_count
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned FILL_W = DEPTH_LOG2 + 1;
    localparam int unsigned BEAT_W = 10;
    localparam int unsigned BIDX_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [15:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q;
    logic [FILL_W-1:0]       fill_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [BIDX_W-1:0]       bidx_q;
    logic [14:0]             addr_q;
    logic                    fs_pend_q;
    logic                    overflow_q;

    logic full;
    logic empty;
    logic pop;
    logic push;
    logic drop;
    logic req;
    logic burst_end;

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign full      = (fill_q == FILL_W'(DEPTH));
    assign empty     = (fill_q == '0);
    assign pop       = f2s_data_valid & ~empty;
    assign push      = pix_valid & (~full | pop);
    assign drop      = pix_valid & full & ~pop;
    assign req       = ready & (fill_q >= FILL_W'(BURST_LEN));
    assign burst_end = (state_q == WRITE) & pop & (beat_q == BEAT_W'(BURST_LEN - 1));

    assign rw         = 1'b0;
    assign f_addr     = addr_q;
    assign f2s_data   = mem[rd_ptr_q];
    assign fill_level = fill_q;
    assign overflow   = overflow_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; the request strobe is combinational so it lands in the controller's ready cycle.
    always_comb begin
        state_d = state_q;
        rw_en   = 1'b0;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                rw_en = req;
                if (req) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                busy = 1'b1;
                if (burst_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage array carries no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= pix_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
            if (push && !pop) begin
                fill_q <= fill_q + FILL_W'(1);
            end else if (pop && !push) begin
                fill_q <= fill_q - FILL_W'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Beat counter restarts on the accepted request and counts pops inside the burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
        end else if (state_q == IDLE && req) begin
            beat_q <= '0;
        end else if (state_q == WRITE && pop) begin
            beat_q <= beat_q + BEAT_W'(1);
        end
    end

    // Burst address sequence; a frame restart seen mid-burst is deferred to the burst end.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= BASE_ADDR;
            bidx_q    <= '0;
            fs_pend_q <= 1'b0;
        end else if (state_q == IDLE) begin
            fs_pend_q <= 1'b0;
            if (frame_start) begin
                addr_q <= BASE_ADDR;
                bidx_q <= '0;
            end
        end else if (burst_end) begin
            fs_pend_q <= 1'b0;
            if (frame_start || fs_pend_q || bidx_q == BIDX_W'(FRAME_BURSTS - 1)) begin
                addr_q <= BASE_ADDR;
                bidx_q <= '0;
            end else begin
                addr_q <= addr_q + 15'd1;
                bidx_q <= bidx_q + BIDX_W'(1);
            end
        end else if (frame_start) begin
            fs_pend_q <= 1'b1;
        end
    end

`ifdef SDRAM_WBUF_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    // Saturating count of pushes lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_sdram_write_buffer.sv
// Directed bench for sdram_write_buffer: vector table for FIFO basics, sequences for bursts,
// address wrap, frame restart, overflow and mid-burst reset.
module tb_sdram_write_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        frame_start;
    logic        ready;
    logic        f2s_data_valid;
    logic        rw_en;
    logic        rw;
    logic [14:0] f_addr;
    logic [15:0] f2s_data;
    logic [10:0] fill_level;
    logic        busy;
    logic        overflow;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sdram_write_buffer #(
        .DEPTH_LOG2  (10),
        .BURST_LEN   (512),
        .FRAME_BURSTS(3),
        .BASE_ADDR   (15'd0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .frame_start   (frame_start),
        .ready         (ready),
        .f2s_data_valid(f2s_data_valid),
        .rw_en         (rw_en),
        .rw            (rw),
        .f_addr        (f_addr),
        .f2s_data      (f2s_data),
        .fill_level    (fill_level),
        .busy          (busy),
        .overflow      (overflow),
        .drop_count    (drop_count)
    );

    typedef struct {
        logic        pv;
        logic [15:0] pd;
        logic        pop;
        logic [10:0] exp_fill;
        logic        chk_head;
        logic [15:0] exp_head;
    } vec_t;

    vec_t vecs[8];

`ifdef SDRAM_WBUF_DROP_CNT_EN
    localparam logic [15:0] EXP_DROPS = 16'd76;
`else
    localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [15:0] base);
        for (int k = 0; k < n; k++) begin
            pix_valid = 1'b1;
            pix_data  = base + 16'(k);
            tick();
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_req(input logic [14:0] exp_addr);
        int n = 0;
        while (rw_en !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", 32'(rw_en), 32'd1);
        check("req_addr", 32'(f_addr), 32'(exp_addr));
        tick();
        check("req_one_cycle", 32'(rw_en), 32'd0);
        check("busy_in_write", 32'(busy), 32'd1);
    endtask

    // Controller model: pops with a gap every fourth cycle, checking show-ahead data.
    task automatic pop_n(input int n, input logic [15:0] base);
        int k = 0;
        int cyc = 0;
        while (k < n && cyc < 4 * n + 10) begin
            if ((cyc % 4) != 3) begin
                check("burst_data", 32'(f2s_data), 32'(base + 16'(k)));
                f2s_data_valid = 1'b1;
                k++;
            end else begin
                f2s_data_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        f2s_data_valid = 1'b0;
        check("burst_pop_count", 32'(k), 32'(n));
    endtask

    task automatic full_burst(input logic [14:0] addr, input logic [15:0] base,
                              input logic [14:0] next_addr);
        push_n(512, base);
        wait_req(addr);
        pop_n(512, base);
        check("burst_end_busy", 32'(busy), 32'd0);
        check("burst_end_addr", 32'(f_addr), 32'(next_addr));
        check("burst_end_fill", 32'(fill_level), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 16'hA001, 1'b0, 11'd1, 1'b1, 16'hA001};
        vecs[1] = '{1'b1, 16'hA002, 1'b0, 11'd2, 1'b1, 16'hA001};
        vecs[2] = '{1'b1, 16'hA003, 1'b1, 11'd2, 1'b1, 16'hA002};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 11'd1, 1'b1, 16'hA003};
        vecs[4] = '{1'b0, 16'h0000, 1'b1, 11'd0, 1'b0, 16'h0000};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, 11'd0, 1'b0, 16'h0000};
        vecs[6] = '{1'b1, 16'hA004, 1'b1, 11'd1, 1'b1, 16'hA004};
        vecs[7] = '{1'b0, 16'h0000, 1'b1, 11'd0, 1'b0, 16'h0000};

        rst            = 1'b1;
        pix_data       = '0;
        pix_valid      = 1'b0;
        frame_start    = 1'b0;
        ready          = 1'b1;
        f2s_data_valid = 1'b0;
        tick();
        tick();
        check("rst_rw_en", 32'(rw_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_addr", 32'(f_addr), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drops", 32'(drop_count), 32'd0);
        check("rw_write", 32'(rw), 32'd0);
        rst = 1'b0;
        tick();

        // FIFO basics: push, pop, simultaneous, pop while empty.
        for (int i = 0; i < 8; i++) begin
            pix_valid      = vecs[i].pv;
            pix_data       = vecs[i].pd;
            f2s_data_valid = vecs[i].pop;
            tick();
            check("vec_fill", 32'(fill_level), 32'(vecs[i].exp_fill));
            if (vecs[i].chk_head) begin
                check("vec_head", 32'(f2s_data), 32'(vecs[i].exp_head));
            end
            check("vec_rw_en", 32'(rw_en), 32'd0);
        end
        pix_valid      = 1'b0;
        f2s_data_valid = 1'b0;

        // First burst: no request at 511 words, request right after the 512th.
        push_n(511, 16'h0000);
        check("fill_511", 32'(fill_level), 32'd511);
        check("no_req_511", 32'(rw_en), 32'd0);
        push_n(1, 16'h01FF);
        check("req_latency", 32'(rw_en), 32'd1);
        wait_req(15'd0);
        pop_n(512, 16'h0000);
        check("b1_busy", 32'(busy), 32'd0);
        check("b1_addr", 32'(f_addr), 32'd1);
        check("b1_fill", 32'(fill_level), 32'd0);

        // frame_start mid-burst: address held, restart applied at burst end.
        push_n(512, 16'h1000);
        wait_req(15'd1);
        pop_n(100, 16'h1000);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("fs_addr_stable", 32'(f_addr), 32'd1);
        check("fs_busy", 32'(busy), 32'd1);
        pop_n(412, 16'h1000 + 16'd100);
        check("fs_end_busy", 32'(busy), 32'd0);
        check("fs_restart_addr", 32'(f_addr), 32'd0);

        // Address wrap at FRAME_BURSTS = 3.
        full_burst(15'd0, 16'h2000, 15'd1);
        full_burst(15'd1, 16'h3000, 15'd2);
        full_burst(15'd2, 16'h4000, 15'd0);

        // frame_start on the request cycle: request uses old address, restart lands next cycle.
        full_burst(15'd0, 16'h5000, 15'd1);
        push_n(512, 16'h6000);
        frame_start = 1'b1;
        check("fsreq_rw_en", 32'(rw_en), 32'd1);
        check("fsreq_old_addr", 32'(f_addr), 32'd1);
        tick();
        frame_start = 1'b0;
        check("fsreq_busy", 32'(busy), 32'd1);
        check("fsreq_new_addr", 32'(f_addr), 32'd0);
        pop_n(512, 16'h6000);
        check("fsreq_end_addr", 32'(f_addr), 32'd1);

        // Overflow: 1100 pushes with ready low.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ready = 1'b0;
        tick();
        push_n(1100, 16'h0000);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_fill", 32'(fill_level), 32'd1024);
        check("ovf_drops", 32'(drop_count), 32'(EXP_DROPS));
        check("ovf_no_req", 32'(rw_en), 32'd0);
        check("ovf_head", 32'(f2s_data), 32'd0);
        pix_valid      = 1'b1;
        pix_data       = 16'hBEEF;
        f2s_data_valid = 1'b1;
        tick();
        pix_valid      = 1'b0;
        f2s_data_valid = 1'b0;
        check("full_pushpop_fill", 32'(fill_level), 32'd1024);
        check("full_pushpop_drops", 32'(drop_count), 32'(EXP_DROPS));
        check("full_pushpop_head", 32'(f2s_data), 32'd1);

        // Reset 200 pops into a burst at a non-base address.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ready = 1'b1;
        tick();
        check("post_rst_overflow", 32'(overflow), 32'd0);
        check("post_rst_drops", 32'(drop_count), 32'd0);
        full_burst(15'd0, 16'h7000, 15'd1);
        push_n(512, 16'h8000);
        wait_req(15'd1);
        pop_n(200, 16'h8000);
        rst = 1'b1;
        tick();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_fill", 32'(fill_level), 32'd0);
        check("midrst_addr", 32'(f_addr), 32'd0);
        check("midrst_rw_en", 32'(rw_en), 32'd0);
        rst = 1'b0;
        tick();
        check("after_rst_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
